tug_referee: RTL and testbench

TUG_REFEREE -- requirements
Module: tug_referee

---
 rtl/tug_referee_pkg.sv | 32 +++
 rtl/tug_referee_if.sv | 33 +++
 rtl/tug_referee_key_edge.sv | 35 +++
 rtl/tug_referee.sv | 129 ++++++++++++
 tb/tb_tug_referee.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tug_referee_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tug_pkg
// Description : Shared types and constants for the tug-of-war referee.
// Revision    : 1.0 - initial release
// ============================================================================
package tug_pkg;

    localparam int unsigned C_N_LIGHTS_DEF    = 9;
    localparam int unsigned C_HOLD_CYCLES_DEF = 4;
    localparam int unsigned C_WIN_SCORE_DEF   = 7;
    localparam int unsigned C_SCORE_W         = 3;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_OVER = 2'd2
    } tug_state_e;

    localparam logic [1:0] C_WIN_NONE  = 2'b00;
    localparam logic [1:0] C_WIN_LEFT  = 2'b01;
    localparam logic [1:0] C_WIN_RIGHT = 2'b10;

    function automatic logic [C_SCORE_W-1:0] sat_inc(
        input logic [C_SCORE_W-1:0] i_val,
        input logic [C_SCORE_W-1:0] i_lim
    );
        return (i_val >= i_lim) ? i_lim : i_val + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tug_referee_if.sv
`default_nettype none
// ============================================================================
// Module      : tug_referee_if
// Description : Player keys, light field and referee outputs as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface tug_referee_if
    import tug_pkg::*;
#(
    parameter int N_LIGHTS = C_N_LIGHTS_DEF
) ();
    logic                  L_key;
    logic                  R_key;
    logic [N_LIGHTS-1:0]   field;
    logic                  L_pulse;
    logic                  R_pulse;
    logic                  round_rst;
    logic [C_SCORE_W-1:0]  L_score;
    logic [C_SCORE_W-1:0]  R_score;
    logic [1:0]            winner;
    logic                  game_over;

    // master: the playfield / player side; slave: the referee
    modport master (
        output L_key, R_key, field,
        input  L_pulse, R_pulse, round_rst, L_score, R_score, winner, game_over
    );
    modport slave (
        input  L_key, R_key, field,
        output L_pulse, R_pulse, round_rst, L_score, R_score, winner, game_over
    );
endinterface
`default_nettype wire

// File: rtl/tug_referee_key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : Rising-edge detector with a registered, gated one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key,
    input  wire logic i_en,
    output logic      o_pulse
);
    logic r_hist_q;
    logic r_pulse_q;
    logic w_pulse_d;

    // History always follows the key so an edge seen while disabled is lost
    always_comb begin
        w_pulse_d = i_en & i_key & ~r_hist_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_q  <= 1'b0;
            r_pulse_q <= 1'b0;
        end else begin
            r_hist_q  <= i_key;
            r_pulse_q <= w_pulse_d;
        end
    end

    assign o_pulse = r_pulse_q;
endmodule
`default_nettype wire

// File: rtl/tug_referee.sv
`default_nettype none
// ============================================================================
// Module      : tug_referee
// Description : Referee FSM for a two-player tug-of-war light game.
// Revision    : 1.0 - initial release
// ============================================================================
module tug_referee
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = C_N_LIGHTS_DEF,
    parameter int HOLD_CYCLES = C_HOLD_CYCLES_DEF,
    parameter int WIN_SCORE   = C_WIN_SCORE_DEF
) (
    input  wire logic     clk,
    input  wire logic     reset,
    tug_referee_if.slave  bus
);
    localparam int                   C_HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [C_HOLD_W-1:0]  C_HOLD_LD  = C_HOLD_W'(HOLD_CYCLES);
    localparam logic [C_HOLD_W-1:0]  C_HOLD_ONE = C_HOLD_W'(1);
    localparam logic [C_SCORE_W-1:0] C_WIN      = C_SCORE_W'(WIN_SCORE);

    tug_state_e            r_state_q,     w_state_d;
    logic [C_HOLD_W-1:0]   r_hold_cnt_q,  w_hold_cnt_d;
    logic [C_SCORE_W-1:0]  r_l_score_q,   w_l_score_d;
    logic [C_SCORE_W-1:0]  r_r_score_q,   w_r_score_d;
    logic [1:0]            r_winner_q,    w_winner_d;
    logic                  r_round_rst_q, w_round_rst_d;
    logic                  r_game_over_q, w_game_over_d;
    logic                  w_l_pulse;
    logic                  w_r_pulse;
    logic                  w_key_en;
    logic                  w_unused_field;

    // Enabling on the next state keeps every pulse inside a PLAY cycle
    assign w_key_en = (w_state_d == PLAY);

    key_edge u_key_edge_l (
        .clk     (clk),
        .rst     (reset),
        .i_key   (bus.L_key),
        .i_en    (w_key_en),
        .o_pulse (w_l_pulse)
    );

    key_edge u_key_edge_r (
        .clk     (clk),
        .rst     (reset),
        .i_key   (bus.R_key),
        .i_en    (w_key_en),
        .o_pulse (w_r_pulse)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_hold_cnt_d  = r_hold_cnt_q;
        w_l_score_d   = r_l_score_q;
        w_r_score_d   = r_r_score_q;
        w_winner_d    = r_winner_q;
        w_round_rst_d = 1'b0;
        case (r_state_q)
            PLAY: begin
                if (w_l_pulse && !w_r_pulse && bus.field[N_LIGHTS-1]) begin
                    w_l_score_d  = sat_inc(r_l_score_q, C_WIN);
                    w_winner_d   = C_WIN_LEFT;
                    w_hold_cnt_d = C_HOLD_LD;
                    w_state_d    = HOLD;
                end else if (w_r_pulse && !w_l_pulse && bus.field[0]) begin
                    w_r_score_d  = sat_inc(r_r_score_q, C_WIN);
                    w_winner_d   = C_WIN_RIGHT;
                    w_hold_cnt_d = C_HOLD_LD;
                    w_state_d    = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt_q <= C_HOLD_ONE) begin
                    w_hold_cnt_d = '0;
                    if ((r_l_score_q == C_WIN) || (r_r_score_q == C_WIN)) begin
                        w_state_d = MATCH_OVER;
                    end else begin
                        w_state_d     = PLAY;
                        w_round_rst_d = 1'b1;
                    end
                end else begin
                    w_hold_cnt_d = r_hold_cnt_q - 1'b1;
                end
            end
            MATCH_OVER: begin
                w_state_d = MATCH_OVER;
            end
            default: begin
                w_state_d = PLAY;
            end
        endcase
        w_game_over_d = (w_state_d == MATCH_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= PLAY;
            r_hold_cnt_q  <= '0;
            r_l_score_q   <= '0;
            r_r_score_q   <= '0;
            r_winner_q    <= C_WIN_NONE;
            r_round_rst_q <= 1'b0;
            r_game_over_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_hold_cnt_q  <= w_hold_cnt_d;
            r_l_score_q   <= w_l_score_d;
            r_r_score_q   <= w_r_score_d;
            r_winner_q    <= w_winner_d;
            r_round_rst_q <= w_round_rst_d;
            r_game_over_q <= w_game_over_d;
        end
    end

    // Only the two end cells matter to the referee
    assign w_unused_field = ^bus.field;

    assign bus.L_pulse   = w_l_pulse;
    assign bus.R_pulse   = w_r_pulse;
    assign bus.round_rst = r_round_rst_q;
    assign bus.L_score   = r_l_score_q;
    assign bus.R_score   = r_r_score_q;
    assign bus.winner    = r_winner_q;
    assign bus.game_over = r_game_over_q;
endmodule
`default_nettype wire

// File: tb/tb_tug_referee.sv
`default_nettype none
// ============================================================================
// Module      : tb_tug_referee
// Description : Self-checking bench for tug_referee against a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_referee;
    import tug_pkg::*;

    localparam int N    = 9;
    localparam int HOLD = 4;
    localparam int WIN  = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tug_referee_if #(.N_LIGHTS(N)) bus ();

    tug_referee #(
        .N_LIGHTS    (N),
        .HOLD_CYCLES (HOLD),
        .WIN_SCORE   (WIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: game phase is "frozen until cycle m_resume" or "over"
    int   cyc = 0;
    int   m_ls, m_rs, m_win, m_resume;
    bit   m_lp, m_rp, m_rr, m_over, m_frozen, m_pl, m_pr;

    task automatic model_step(input bit rst_v, input bit lk, input bit rk, input logic [N-1:0] fld);
        bit win_l, win_r, play;
        cyc++;
        if (rst_v) begin
            m_ls = 0; m_rs = 0; m_win = 0; m_resume = 0;
            m_lp = 0; m_rp = 0; m_rr = 0; m_over = 0; m_frozen = 0; m_pl = 0; m_pr = 0;
            return;
        end
        play  = !m_frozen && !m_over;
        win_l = play && m_lp && !m_rp && fld[N-1];
        win_r = play && m_rp && !m_lp && fld[0];
        m_rr  = 0;
        if (win_l) begin
            m_ls = (m_ls + 1 > WIN) ? WIN : m_ls + 1;
            m_win = 1; m_frozen = 1; m_resume = cyc + HOLD;
        end else if (win_r) begin
            m_rs = (m_rs + 1 > WIN) ? WIN : m_rs + 1;
            m_win = 2; m_frozen = 1; m_resume = cyc + HOLD;
        end else if (m_frozen && cyc == m_resume) begin
            m_frozen = 0;
            if (m_ls == WIN || m_rs == WIN) m_over = 1;
            else m_rr = 1;
        end
        play = !m_frozen && !m_over;
        m_lp = play && lk && !m_pl;
        m_rp = play && rk && !m_pr;
        m_pl = lk;
        m_pr = rk;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, bus.L_key, bus.R_key, bus.field);
        #1;
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.L_pulse, bus.R_pulse, bus.round_rst, bus.L_score, bus.R_score,
                bus.winner, bus.game_over};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {m_lp, m_rp, m_rr, 3'(m_ls), 3'(m_rs), 2'(m_win), m_over};
    endfunction

    task automatic test_reset();
        reset = 1; bus.L_key = 0; bus.R_key = 0; bus.field = '0;
        for (int i = 0; i < 3; i++) begin
            tick(); vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (dut_vec() !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_zero got=%b exp=%b", dut_vec(), 12'd0);
        end
        reset = 0;
    endtask

    task automatic test_single_press();
        int np = 0;
        bus.field = '0; bus.L_key = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) bus.L_key = 0;
            tick(); vectors++;
            np += int'(bus.L_pulse);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_press cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (np != 1 || bus.L_score !== 3'd0 || bus.R_score !== 3'd0) begin
            miscompares++;
            $display("FAIL single_press_count pulses=%0d scores=%0d/%0d exp 1,0/0", np, bus.L_score, bus.R_score);
        end
    endtask

    task automatic test_simultaneous();
        int nboth = 0;
        bus.field = 9'b1_0000_0001; bus.L_key = 1; bus.R_key = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin bus.L_key = 0; bus.R_key = 0; end
            tick(); vectors++;
            nboth += int'(bus.L_pulse && bus.R_pulse);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (nboth != 1 || bus.L_score !== 3'd0 || bus.R_score !== 3'd0 || bus.winner !== 2'b00) begin
            miscompares++;
            $display("FAIL simultaneous_noscore both=%0d L=%0d R=%0d w=%b exp 1,0,0,00",
                     nboth, bus.L_score, bus.R_score, bus.winner);
        end
    endtask

    task automatic test_left_win();
        int nrr = 0;
        reset = 1; bus.L_key = 0; bus.R_key = 0; tick(); reset = 0;
        bus.field = 9'b1_0000_0000; bus.L_key = 1;
        for (int i = 0; i < 10; i++) begin
            tick(); vectors++;
            nrr += int'(bus.round_rst);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL left_win cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            bus.L_key = (i >= 1 && i <= 4) ? 1'(i % 2) : 1'b0;
            bus.R_key = (i == 2);
        end
        vectors++;
        if (bus.L_score !== 3'd1 || bus.winner !== 2'b01 || nrr != 1) begin
            miscompares++;
            $display("FAIL left_win_result L=%0d w=%b rr=%0d exp 1,01,1", bus.L_score, bus.winner, nrr);
        end
    endtask

    task automatic test_right_match();
        int nrr = 0;
        int np  = 0;
        reset = 1; bus.L_key = 0; bus.R_key = 0; tick(); reset = 0;
        bus.field = 9'b0_0000_0001;
        for (int r = 0; r < WIN; r++) begin
            for (int i = 0; i < HOLD + 3; i++) begin
                bus.R_key = (i == 0);
                tick(); vectors++;
                nrr += int'(bus.round_rst);
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL right_match cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (bus.R_score !== 3'd7 || bus.game_over !== 1'b1 || nrr != WIN - 1 || bus.winner !== 2'b10) begin
            miscompares++;
            $display("FAIL right_match_result R=%0d go=%b rr=%0d w=%b exp 7,1,6,10",
                     bus.R_score, bus.game_over, nrr, bus.winner);
        end
        for (int i = 0; i < 8; i++) begin
            bus.R_key = i[0]; bus.L_key = ~i[0];
            tick(); vectors++;
            np += int'(bus.L_pulse) + int'(bus.R_pulse) + int'(bus.round_rst);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL match_over cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (np != 0 || bus.R_score !== 3'd7 || bus.game_over !== 1'b1) begin
            miscompares++;
            $display("FAIL match_over_frozen strobes=%0d R=%0d exp 0,7", np, bus.R_score);
        end
        bus.L_key = 0; bus.R_key = 0;
    endtask

    task automatic test_reset_mid_hold();
        int nrr = 0;
        reset = 1; tick(); reset = 0;
        bus.field = 9'b1_0000_0000; bus.L_key = 1;
        tick(); bus.L_key = 0;
        tick(); tick();
        reset = 1;
        tick(); reset = 0;
        vectors++;
        if (dut_vec() !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_mid_hold got=%b exp=%b", dut_vec(), 12'd0);
        end
        for (int i = 0; i < 6; i++) begin
            tick(); vectors++;
            nrr += int'(bus.round_rst);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_hold_after cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (nrr != 0) begin
            miscompares++;
            $display("FAIL reset_mid_hold_rr got=%0d exp=0", nrr);
        end
    endtask

    task automatic test_reset_held_key();
        int np = 0;
        bus.field = '0; bus.R_key = 1; reset = 1;
        tick(); tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); vectors++;
            if (i == 0 && bus.R_pulse !== 1'b1) begin
                miscompares++;
                $display("FAIL held_key_first got=%b exp=1", bus.R_pulse);
            end
            np += int'(bus.R_pulse);
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL held_key cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (np != 1) begin
            miscompares++;
            $display("FAIL held_key_count got=%0d exp=1", np);
        end
        bus.R_key = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(2) == 0) bus.L_key = ~bus.L_key;
            if ($urandom_range(2) == 0) bus.R_key = ~bus.R_key;
            bus.field = N'($urandom);
            if ($urandom_range(1) == 0) bus.field[N-1] = 1'b1;
            if ($urandom_range(1) == 0) bus.field[0] = 1'b1;
            tick(); vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_left_win();
        test_right_match();
        test_reset_mid_hold();
        test_reset_held_key();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
